match_frame_controller: RTL and testbench

- Sequences the byte-match datapath between the serial receiver and the serial transmitter.
- Parses each received frame: the first byte is the payload length N, followed by N payload bytes.
- Counts payload bytes that equal a pattern byte latched at frame start.
- Hands the 8-bit count to the transmitter over a start/busy handshake, with inter-byte timeout and overrun detection.

---
 rtl/match_frame_controller.sv | 167 ++++++++++++++++
 tb/tb_match_frame_controller.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/match_frame_controller.sv
// match_frame_controller: parses length-prefixed frames, counts payload bytes
// equal to a pattern latched on the length byte, and reports the count to a
// serial transmitter over a start/busy handshake. An idle gap between payload
// bytes aborts the frame, and bytes that arrive while a report is pending are
// dropped and flagged.
module match_frame_controller #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 1023,
    parameter int TO_W    = 10
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] Rx_data,
    input  logic              Rx_valid,
    input  logic [DATA_W-1:0] Pattern,
    input  logic              Tx_busy,
    output logic              Tx_start,
    output logic [DATA_W-1:0] Tx_data,
    output logic [DATA_W-1:0] Match_count,
    output logic              Busy,
    output logic              Frame_error,
    output logic              Overrun
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_REPORT  = 2'd2,
        S_WAIT_TX = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [DATA_W-1:0] r_remaining;
    logic [DATA_W-1:0] r_count;
    logic [DATA_W-1:0] r_pat;
    logic [TO_W-1:0]   r_timeout;
    logic              r_wait_first;
    logic              r_tx_start;
    logic [DATA_W-1:0] r_tx_data;
    logic [DATA_W-1:0] r_match;
    logic              r_ferr;
    logic              r_ovr;

    logic              w_hit;
    logic              w_last;
    logic              w_to_expire;

    assign w_hit       = (Rx_data == r_pat);
    assign w_last      = (r_remaining == DATA_W'(1));
    // The counter is compared before it increments, so the abort lands on
    // exactly the TIMEOUT-th consecutive idle cycle after the last byte.
    assign w_to_expire = (r_timeout == TO_W'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; a received byte always takes priority over the timeout.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (Rx_valid) begin
                    w_next = (Rx_data == '0) ? S_REPORT : S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (Rx_valid) begin
                    if (w_last) begin
                        w_next = S_REPORT;
                    end
                end else if (w_to_expire) begin
                    w_next = S_IDLE;
                end
            end
            S_REPORT: begin
                if (!Tx_busy) begin
                    w_next = S_WAIT_TX;
                end
            end
            S_WAIT_TX: begin
                // The transmitter may take a cycle to raise busy after start.
                if (!r_wait_first && !Tx_busy) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Frame datapath, report registers and one-cycle status pulses.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_remaining  <= '0;
            r_count      <= '0;
            r_pat        <= '0;
            r_timeout    <= '0;
            r_wait_first <= 1'b0;
            r_tx_start   <= 1'b0;
            r_tx_data    <= '0;
            r_match      <= '0;
            r_ferr       <= 1'b0;
            r_ovr        <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            r_ferr     <= 1'b0;
            r_ovr      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Rx_valid) begin
                        r_remaining <= Rx_data;
                        r_pat       <= Pattern;
                        r_count     <= '0;
                        r_timeout   <= '0;
                    end
                end
                S_PAYLOAD: begin
                    if (Rx_valid) begin
                        if (w_hit) begin
                            r_count <= r_count + DATA_W'(1);
                        end
                        r_remaining <= r_remaining - DATA_W'(1);
                        r_timeout   <= '0;
                    end else if (w_to_expire) begin
                        r_ferr    <= 1'b1;
                        r_timeout <= '0;
                    end else begin
                        r_timeout <= r_timeout + TO_W'(1);
                    end
                end
                S_REPORT: begin
                    if (Rx_valid) begin
                        r_ovr <= 1'b1;
                    end
                    if (!Tx_busy) begin
                        r_tx_start   <= 1'b1;
                        r_tx_data    <= r_count;
                        r_match      <= r_count;
                        r_wait_first <= 1'b1;
                    end
                end
                S_WAIT_TX: begin
                    if (Rx_valid) begin
                        r_ovr <= 1'b1;
                    end
                    r_wait_first <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign Tx_start    = r_tx_start;
    assign Tx_data     = r_tx_data;
    assign Match_count = r_match;
    assign Busy        = (r_state != S_IDLE);
    assign Frame_error = r_ferr;
    assign Overrun     = r_ovr;

endmodule

// File: tb/tb_match_frame_controller.sv
// Scoreboard bench for match_frame_controller: directed frames push their
// expected reports, error pulses and output snapshots into queues; a monitor
// on the falling edge pops and compares them as the DUT presents outputs.
module tb_match_frame_controller;

    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 1023;
    localparam int TO_W    = 10;

    logic              Clk;
    logic              Reset;
    logic [DATA_W-1:0] Rx_data;
    logic              Rx_valid;
    logic [DATA_W-1:0] Pattern;
    logic              Tx_busy;
    logic              Tx_start;
    logic [DATA_W-1:0] Tx_data;
    logic [DATA_W-1:0] Match_count;
    logic              Busy;
    logic              Frame_error;
    logic              Overrun;

    match_frame_controller #(
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT),
        .TO_W   (TO_W)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Rx_data    (Rx_data),
        .Rx_valid   (Rx_valid),
        .Pattern    (Pattern),
        .Tx_busy    (Tx_busy),
        .Tx_start   (Tx_start),
        .Tx_data    (Tx_data),
        .Match_count(Match_count),
        .Busy       (Busy),
        .Frame_error(Frame_error),
        .Overrun    (Overrun)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Simple transmitter: busy for four cycles starting the edge after Tx_start.
    logic [2:0] m_cnt;
    logic       force_busy;
    always @(posedge Clk) begin
        if (Tx_start) m_cnt <= 3'd4;
        else if (m_cnt != 3'd0) m_cnt <= m_cnt - 3'd1;
    end
    assign Tx_busy = (m_cnt != 3'd0) | force_busy;

    // Scoreboard queues.
    logic [DATA_W-1:0] tx_q[$];
    string             fe_q[$];
    string             ov_q[$];
    logic [19:0]       snap_q[$];
    string             snap_name_q[$];

    int n_chk  = 0;
    int n_pass = 0;
    bit done_req = 1'b0;
    bit done_ack = 1'b0;

    // Monitor: compares every DUT event and every requested snapshot.
    initial begin
        logic [DATA_W-1:0] e;
        logic [19:0]       s;
        logic [19:0]       act;
        string             nm;
        forever begin
            @(negedge Clk);
            if (Tx_start) begin
                n_chk++;
                if (tx_q.size() == 0) begin
                    $display("FAIL tx_start_unexpected: got Tx_data=%h, expected no report", Tx_data);
                end else begin
                    e = tx_q.pop_front();
                    if (Tx_data == e && Match_count == e) n_pass++;
                    else $display("FAIL tx_report: got Tx_data=%h Match_count=%h, expected %h", Tx_data, Match_count, e);
                end
            end
            if (Frame_error) begin
                n_chk++;
                if (fe_q.size() == 0) $display("FAIL frame_error_unexpected: got 1, expected 0");
                else begin
                    nm = fe_q.pop_front();
                    n_pass++;
                end
            end
            if (Overrun) begin
                n_chk++;
                if (ov_q.size() == 0) $display("FAIL overrun_unexpected: got 1, expected 0");
                else begin
                    nm = ov_q.pop_front();
                    n_pass++;
                end
            end
            if (snap_q.size() != 0) begin
                s   = snap_q.pop_front();
                nm  = snap_name_q.pop_front();
                act = {Busy, Tx_start, Frame_error, Overrun, Tx_data, Match_count};
                n_chk++;
                if (act == s) n_pass++;
                else $display("FAIL %s: got {busy,start,ferr,ovr,txd,mc}=%h, expected %h", nm, act, s);
            end
            if (done_req && !done_ack) begin
                n_chk++;
                if (tx_q.size() == 0) n_pass++;
                else $display("FAIL tx_missing: got %0d reports outstanding, expected 0", tx_q.size());
                n_chk++;
                if (fe_q.size() == 0) n_pass++;
                else $display("FAIL frame_error_missing: got %0d outstanding, expected 0", fe_q.size());
                n_chk++;
                if (ov_q.size() == 0) n_pass++;
                else $display("FAIL overrun_missing: got %0d outstanding, expected 0", ov_q.size());
                done_ack = 1'b1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [DATA_W-1:0] b);
        Rx_data  = b;
        Rx_valid = 1'b1;
        @(posedge Clk);
        #1;
        Rx_valid = 1'b0;
        Rx_data  = '0;
    endtask

    task automatic snap(input string nm, input logic b, input logic ts, input logic fe,
                        input logic ov, input logic [7:0] td, input logic [7:0] mc);
        snap_q.push_back({b, ts, fe, ov, td, mc});
        snap_name_q.push_back(nm);
    endtask

    initial begin
        Reset      = 1'b1;
        Rx_data    = '0;
        Rx_valid   = 1'b0;
        Pattern    = 8'h41;
        force_busy = 1'b0;
        m_cnt      = 3'd0;
        #2;
        snap("reset_state", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick(3);
        Reset = 1'b0;
        tick(2);

        // Frame 1: 'A' appears three times.
        tx_q.push_back(8'h03);
        send_byte(8'h05);
        send_byte(8'h41);
        send_byte(8'h42);
        send_byte(8'h41);
        send_byte(8'h41);
        send_byte(8'h43);
        snap("f1_report_state", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick(1);
        snap("f1_tx_start", 1'b1, 1'b1, 1'b0, 1'b0, 8'h03, 8'h03);
        tick(11);
        snap("f1_idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h03, 8'h03);
        tick(1);

        // Frame 2: empty frame goes straight to report.
        tx_q.push_back(8'h00);
        send_byte(8'h00);
        snap("f2_report_state", 1'b1, 1'b0, 1'b0, 1'b0, 8'h03, 8'h03);
        tick(1);
        snap("f2_tx_start", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        tick(12);

        // Frame 3: pattern change after the length byte is ignored.
        tx_q.push_back(8'h02);
        Pattern = 8'h41;
        send_byte(8'h03);
        Pattern = 8'h42;
        send_byte(8'h41);
        send_byte(8'h42);
        send_byte(8'h41);
        tick(12);
        snap("f3_idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h02, 8'h02);
        tick(1);

        // Frame 4: two of four bytes, then the timeout aborts it.
        Pattern = 8'h41;
        fe_q.push_back("timeout");
        send_byte(8'h04);
        send_byte(8'h41);
        send_byte(8'h41);
        tick(TIMEOUT - 1);
        snap("f4_before_timeout", 1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 8'h02);
        tick(1);
        snap("f4_timeout_abort", 1'b0, 1'b0, 1'b1, 1'b0, 8'h02, 8'h02);
        tick(1);
        snap("f4_after_abort", 1'b0, 1'b0, 1'b0, 1'b0, 8'h02, 8'h02);
        tick(5);

        // Frame 5: transmitter held busy; a byte during REPORT overruns.
        force_busy = 1'b1;
        tx_q.push_back(8'h01);
        send_byte(8'h01);
        send_byte(8'h41);
        tick(5);
        ov_q.push_back("report_overrun");
        send_byte(8'h41);
        snap("f5_overrun", 1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 8'h02);
        tick(14);
        snap("f5_held", 1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 8'h02);
        force_busy = 1'b0;
        tick(1);
        snap("f5_tx_start", 1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 8'h01);
        tick(12);

        // Frame 6: counted correctly after the held report.
        tx_q.push_back(8'h02);
        send_byte(8'h03);
        send_byte(8'h41);
        send_byte(8'h41);
        send_byte(8'h42);
        tick(12);
        snap("f6_idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h02, 8'h02);
        tick(1);

        // Frame 7: reset mid-payload discards the frame at once.
        send_byte(8'h0A);
        send_byte(8'h41);
        send_byte(8'h41);
        send_byte(8'h41);
        send_byte(8'h41);
        #2;
        Reset = 1'b1;
        snap("mid_frame_reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        tick(3);

        // Frame 8: normal frame after reset.
        tx_q.push_back(8'h02);
        Pattern = 8'h41;
        send_byte(8'h02);
        send_byte(8'h41);
        send_byte(8'h41);
        tick(12);
        snap("f8_idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h02, 8'h02);
        tick(2);

        done_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clk);
            if (done_ack) break;
        end
        if (!done_ack) begin
            $display("FAIL monitor_done: got no final check, expected it within 20 cycles");
            $fatal(1, "monitor did not complete");
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
